// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter that drains a first-word-fall-through TX FIFO, one word per frame.
// Optional even-parity bit between data and stop, enabled by defining UART_TX_PARITY_EN.
// Ports: clk, reset (synchronous, active-high); s_tick 16x-baud pulse; empty/r_data FIFO head;
//   rd one-clk pop strobe; tx registered serial line (idle high); tx_busy frame in progress;
//   tx_done_tick one-clk pulse on the last tick of the stop period.
module uart_tx_drain #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [4:0] t, t_n;
  logic [3:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic tx_n;
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk)
    par <= reset ? 1'b0 : rd ? ^r_data : par;
`endif
  always_comb begin
    state_n = state;
    t_n = t;
    n_n = n;
    b_n = b;
    rd = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE:
        if (!empty && !reset) begin
          rd = 1'b1;
          b_n = r_data;
          t_n = '0;
          state_n = START;
        end
      START:
        if (s_tick) begin
          if (t == 5'd15) begin
            t_n = '0;
            n_n = '0;
            state_n = DATA;
          end else t_n = t + 5'd1;
        end
      DATA:
        if (s_tick) begin
          if (t == 5'd15) begin
            t_n = '0;
            b_n = b >> 1;
            if (n == 4'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            else n_n = n + 4'd1;
          end else t_n = t + 5'd1;
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (s_tick) begin
          if (t == 5'd15) begin
            t_n = '0;
            state_n = STOP;
          end else t_n = t + 5'd1;
        end
`endif
      STOP:
        if (s_tick) begin
          if (t == 5'(SB_TICK - 1)) begin
            tx_done_tick = 1'b1;
            t_n = '0;
            state_n = IDLE;
          end else t_n = t + 5'd1;
        end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line changes together with the state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? b_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_n == PARITY) tx_n = par;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t <= '0;
      n <= '0;
      b <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      t <= t_n;
      n <= n_n;
      b <= b_n;
      tx <= tx_n;
    end
  end
  assign tx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: randomized scoreboard bench for uart_tx_drain against a bit-time frame model.
module tb_uart_tx_drain;
  localparam int DBIT = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NT = (1 + DBIT + PB) * 16 + SB_TICK;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic empty;
  logic [DBIT-1:0] r_data;
  logic rd, tx, tx_busy, tx_done_tick;
  logic push_req = 1'b0;
  logic [DBIT-1:0] push_val = '0;
  logic fin = 1'b0;
  logic [DBIT-1:0] fifo_q[$];
  logic [DBIT-1:0] exp_q[$];
  int mode = 0;
  int cyc = 0;
  int nc = 0, nf = 0;
  int rd_idx = 0, tk = 0, frames = 0;
  logic busy_m = 1'b0, armed = 1'b0, prev_rst = 1'b0, rd_m, last;
  logic [DBIT-1:0] cur = '0, got = '0;

  uart_tx_drain #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  function automatic logic exp_tx(logic [DBIT-1:0] w, int k);
    logic [DBIT-1:0] s;
    if (k < 16) return 1'b0;
    if (k < 16 * (1 + DBIT)) begin
      s = w >> ((k - 16) / 16);
      return s[0];
    end
    if (PB == 1 && k < 16 * (2 + DBIT)) return ^w;
    return 1'b1;
  endfunction

  function automatic void chk(string nm, int act, int req);
    nc++;
    if (act != req) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // FWFT FIFO model feeding the DUT; every accepted word is also the expected output
  initial begin
    empty = 1'b1;
    r_data = '0;
    forever begin
      @(posedge clk);
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (push_req) begin
        fifo_q.push_back(push_val);
        exp_q.push_back(push_val);
      end
      empty <= fifo_q.size() == 0;
      r_data <= fifo_q.size() > 0 ? fifo_q[0] : '0;
    end
  end

  // Monitor: frame model in bit times, tick-accurate, compared on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst) armed = 1'b1;
      if (armed) begin
        rd_m = !reset && !busy_m && !empty;
        chk("rd", int'(rd), int'(rd_m));
        chk("tx_busy", int'(tx_busy), int'(busy_m));
        chk("tx", int'(tx), busy_m ? int'(exp_tx(cur, tk)) : 1);
        last = busy_m && s_tick && tk == NT - 1;
        chk("tx_done_tick", int'(tx_done_tick), int'(last));
        if (busy_m && s_tick) begin
          if (tk >= 16 && tk < 16 * (1 + DBIT) && (tk - 16) % 16 == 8) got = {tx, got[DBIT-1:1]};
          tk++;
        end
        if (last) begin
          chk("word", int'(got), int'(cur));
          frames++;
          busy_m = 1'b0;
        end
        if (rd_m) begin
          if (rd_idx < exp_q.size()) cur = exp_q[rd_idx];
          rd_idx++;
          busy_m = 1'b1;
          tk = 0;
          got = '0;
        end
        if (reset) busy_m = 1'b0;
      end
      prev_rst = reset;
      if (fin) begin
        chk("pops", rd_idx, exp_q.size());
        chk("frames", frames, exp_q.size() - 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
      end
    end
  end

  task automatic clk1(logic p, logic [DBIT-1:0] v);
    @(posedge clk);
    #1;
    cyc++;
    s_tick = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0) : ($urandom_range(0, 2) == 0);
    push_req = p;
    push_val = v;
  endtask

  task automatic step(int k);
    repeat (k) clk1(1'b0, '0);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    clk1(1'b1, 8'hA5);
    step(200);
    clk1(1'b1, 8'h00);
    clk1(1'b1, 8'hFF);
    step(400);
    step(1000);
    mode = 1;
    clk1(1'b1, 8'h3C);
    step(700);
    mode = 0;
    clk1(1'b1, 8'h5A);
    clk1(1'b1, 8'h77);
    step(52);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(300);
    repeat (30) begin
      mode = $urandom_range(0, 2);
      clk1(1'b1, DBIT'($urandom));
      step($urandom_range(0, 600));
    end
    step(2);
    for (int i = 0; i < 40000 && (!empty || tx_busy); i++) step(1);
    step(5);
    fin = 1'b1;
  end
endmodule
